// File: rtl/exe_result_if.sv
// exe_result_if: upstream/downstream handshake, flag and condition signals of the result stage.
interface exe_result_if #(parameter int bus = 32, parameter int reg_bits = 4);
  logic                in_valid;
  logic                in_ready;
  logic [bus-1:0]      in_result;
  logic                in_negative;
  logic                in_zero;
  logic                in_carry_out;
  logic                in_overflow;
  logic                in_set_flags;
  logic [reg_bits-1:0] in_rd;
  logic                in_write_en;
  logic                out_valid;
  logic                out_ready;
  logic [bus-1:0]      out_result;
  logic [reg_bits-1:0] out_rd;
  logic                out_write_en;
  logic [3:0]          flags;
  logic [3:0]          cond;
  logic                cond_true;
  modport master (
    output in_valid, in_result, in_negative, in_zero, in_carry_out, in_overflow,
           in_set_flags, in_rd, in_write_en, out_ready, cond,
    input  in_ready, out_valid, out_result, out_rd, out_write_en, flags, cond_true
  );
  modport slave (
    input  in_valid, in_result, in_negative, in_zero, in_carry_out, in_overflow,
           in_set_flags, in_rd, in_write_en, out_ready, cond,
    output in_ready, out_valid, out_result, out_rd, out_write_en, flags, cond_true
  );
endinterface

// File: rtl/exe_result_stage.sv
// exe_result_stage: 2-entry skid buffer after the adder, NZCV flag register and condition evaluation.
module exe_result_stage #(parameter int bus = 32, parameter int reg_bits = 4) (
  input logic         clk,
  input logic         rst,
  exe_result_if.slave bi
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, nxt;
  logic acc, emi, n, z, c, v;
  logic [bus+reg_bits:0] head, skid, ent;
  logic [3:0] flg;
  logic [15:0] tbl;
  assign ent = {bi.in_result, bi.in_rd, bi.in_write_en};
  assign bi.in_ready = state != TWO;
  assign bi.out_valid = state != EMPTY;
  assign acc = bi.in_valid & bi.in_ready;
  assign emi = bi.out_valid & bi.out_ready;
  assign {bi.out_result, bi.out_rd, bi.out_write_en} = head;
  assign bi.flags = flg;
  always_comb begin
    nxt = state;
    case (state)
      EMPTY:   nxt = acc ? ONE : EMPTY;
      ONE:     nxt = (acc & ~emi) ? TWO : (emi & ~acc) ? EMPTY : ONE;
      TWO:     nxt = emi ? ONE : TWO;
      default: nxt = EMPTY;
    endcase
  end
  // head is always the oldest entry; skid only fills when head is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
      flg   <= 4'b0000;
    end else begin
      state <= nxt;
      if (acc && (state == EMPTY || emi)) head <= ent;
      else if (emi && state == TWO) head <= skid;
      if (acc && state == ONE && !emi) skid <= ent;
      if (acc && bi.in_set_flags) flg <= {bi.in_negative, bi.in_zero, bi.in_carry_out, bi.in_overflow};
    end
  end
  assign {n, z, c, v} = flg;
  assign tbl = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
                ~v, v, ~n, n, ~c, c, ~z, z};
  assign bi.cond_true = tbl[bi.cond];
endmodule

// File: tb/tb_exe_result_stage.sv
// tb_exe_result_stage: directed and random stimulus against a queue-based reference model.
module tb_exe_result_stage;
  logic clk = 0, rst = 1;
  int total = 0, bad = 0;
  logic [36:0] q[$];
  logic [3:0] mf = 4'b0000;
  exe_result_if #(.bus(32), .reg_bits(4)) bi();
  exe_result_stage #(.bus(32), .reg_bits(4)) dut (.clk(clk), .rst(rst), .bi(bi));
  always #5 clk = ~clk;

  function automatic logic cref(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 64'(bi.in_ready), 64'(q.size() < 2));
    chk("out_valid", 64'(bi.out_valid), 64'(q.size() > 0));
    if (q.size() > 0) chk("out_entry", 64'({bi.out_result, bi.out_rd, bi.out_write_en}), 64'(q[0]));
    chk("flags", 64'(bi.flags), 64'(mf));
    chk("cond_true", 64'(bi.cond_true), 64'(cref(bi.cond, mf)));
  endtask

  task automatic cyc();
    logic acc, emi;
    logic [36:0] e;
    acc = bi.in_valid && q.size() < 2;
    emi = bi.out_ready && q.size() > 0;
    e = {bi.in_result, bi.in_rd, bi.in_write_en};
    if (acc && bi.in_set_flags) mf = {bi.in_negative, bi.in_zero, bi.in_carry_out, bi.in_overflow};
    @(posedge clk);
    if (emi) void'(q.pop_front());
    if (acc) q.push_back(e);
    #1 check_all();
  endtask

  task automatic put(input logic v, input logic [31:0] r, input logic sf, input logic [3:0] f);
    bi.in_valid = v;
    bi.in_result = r;
    bi.in_set_flags = sf;
    {bi.in_negative, bi.in_zero, bi.in_carry_out, bi.in_overflow} = f;
    bi.in_rd = r[3:0] ^ 4'h5;
    bi.in_write_en = r[0];
  endtask

  initial begin
    put(0, 0, 0, 0);
    bi.out_ready = 0;
    bi.cond = 4'hE;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bi.out_valid), 0);
    chk("rst_in_ready", 64'(bi.in_ready), 1);
    chk("rst_out_result", 64'(bi.out_result), 0);
    chk("rst_out_rd", 64'(bi.out_rd), 0);
    chk("rst_out_we", 64'(bi.out_write_en), 0);
    chk("rst_flags", 64'(bi.flags), 0);
    rst = 0;
    // streaming
    bi.out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      put(1, 32'(i), 0, 0);
      cyc();
    end
    put(0, 0, 0, 0);
    cyc();
    // backpressure
    bi.out_ready = 0;
    put(1, 32'hA, 0, 0);
    cyc();
    put(1, 32'hB, 0, 0);
    cyc();
    chk("bp_in_ready", 64'(bi.in_ready), 0);
    put(0, 0, 0, 0);
    cyc();
    chk("bp_hold", 64'(bi.out_result), 32'hA);
    bi.out_ready = 1;
    cyc();
    chk("bp_second", 64'(bi.out_result), 32'hB);
    cyc();
    // flags
    put(1, 32'h11, 1, 4'b1010);
    cyc();
    put(1, 32'h12, 0, 4'b0100);
    cyc();
    chk("flags_kept", 64'(bi.flags), 4'b1010);
    put(0, 0, 0, 0);
    bi.cond = 4'hB;
    #1 chk("cond_lt", 64'(bi.cond_true), 1);
    bi.cond = 4'hA;
    #1 chk("cond_ge", 64'(bi.cond_true), 0);
    cyc();
    // condition sweep over all flag values
    for (int f = 0; f < 16; f++) begin
      bi.out_ready = 1;
      put(1, 32'(f + 100), 1, 4'(f));
      cyc();
      put(0, 0, 0, 0);
      cyc();
      bi.out_ready = 0;
      for (int cc = 0; cc < 16; cc++) begin
        bi.cond = 4'(cc);
        #1 chk($sformatf("sweep_f%0h_c%0h", f, cc), 64'(bi.cond_true), 64'(cref(4'(cc), 4'(f))));
      end
      cyc();
    end
    // refused input while full
    bi.out_ready = 0;
    put(1, 32'h21, 1, 4'b0001);
    cyc();
    put(1, 32'h22, 0, 0);
    cyc();
    put(1, 32'h23, 1, 4'b1110);
    cyc();
    chk("refused_flags", 64'(bi.flags), 4'b0001);
    put(0, 0, 0, 0);
    bi.out_ready = 1;
    repeat (3) cyc();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      put($urandom_range(0, 1), $urandom, $urandom_range(0, 1), 4'($urandom));
      bi.out_ready = $urandom_range(0, 3) != 0;
      bi.cond = 4'($urandom);
      cyc();
    end
    // asynchronous reset with the buffer full
    bi.out_ready = 0;
    put(1, 32'h31, 1, 4'b1111);
    repeat (3) cyc();
    put(0, 0, 0, 0);
    chk("pre_rst_full", 64'(bi.in_ready), 0);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", 64'(bi.out_valid), 0);
    chk("arst_in_ready", 64'(bi.in_ready), 1);
    chk("arst_flags", 64'(bi.flags), 0);
    q.delete();
    mf = 0;
    #2 rst = 0;
    @(posedge clk);
    #1;
    put(1, 32'h41, 0, 0);
    cyc();
    put(0, 0, 0, 0);
    cyc();
    chk("post_rst_single", 64'(bi.in_ready), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exe_result_stage.md
Name: exe_result_stage

Overview:
Pipeline register stage directly downstream of the arithmetic adder. It captures the adder result, the destination register tag and the NZCV flags, and buffers them in a 2-entry skid buffer with valid/ready handshakes toward writeback. It holds the architectural flag register and evaluates 4-bit condition codes against it for conditional execution and branches.

Parameters:
bus, 32, data width of result (matches adder bus)
reg_bits, 4, width of destination register tag

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept an entry
in_result  input  bus  adder result
in_negative  input  1  adder negative flag
in_zero  input  1  adder zero flag
in_carry_out  input  1  adder carry flag
in_overflow  input  1  adder overflow flag
in_set_flags  input  1  accepted entry updates flag register
in_rd  input  reg_bits  destination register tag
in_write_en  input  1  entry writes register file
out_valid  output  1  downstream entry valid
out_ready  input  1  downstream accepts entry
out_result  output  bus  buffered result
out_rd  output  reg_bits  buffered destination tag
out_write_en  output  1  buffered write enable
flags  output  4  flag register {N,Z,C,V}
cond  input  4  condition code to evaluate
cond_true  output  1  cond satisfied by current flags

Behaviour:
- Reset (async, rst=1): state EMPTY; out_valid=0, in_ready=1, out_result=0, out_rd=0, out_write_en=0, flags=4'b0000. Reset asserted mid-transfer discards all buffered entries; no partial entry survives.
- Accept = in_valid & in_ready at rising edge; emit = out_valid & out_ready at rising edge.
- FSM states: EMPTY (0 entries), ONE (1), TWO (2).
  - EMPTY: accept -> ONE. Else stay.
  - ONE: accept & emit -> ONE (new entry moves to output); accept & !emit -> TWO; emit & !accept -> EMPTY; neither -> stay.
  - TWO: emit -> ONE (skid entry promoted to output); no accept possible.
- in_ready = (state != TWO), registered/derived from state only; no combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY). Latency: entry accepted at edge k is on outputs with out_valid=1 after edge k when buffer was EMPTY.
- While out_valid=1 and out_ready=0, out_result/out_rd/out_write_en hold stable.
- Strict FIFO order; no entry dropped or duplicated.
- Flag register: on accept with in_set_flags=1, flags <= {in_negative, in_zero, in_carry_out, in_overflow} at that edge. Accept with in_set_flags=0 or no accept: flags unchanged. Flag update is independent of downstream stall.
- cond_true is combinational from flags and cond: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0.
- cond_true reflects flags committed at previous edges only (no same-cycle bypass of in_* flags).
- in_valid with in_ready=0: entry ignored, flags unchanged; upstream must hold.

Test Plan:
- Reset mid-stream: fill to TWO, assert rst asynchronously between edges -> out_valid=0, in_ready=1, flags=0000 immediately; first post-reset accept appears alone.
- Streaming with out_ready=1: send results 1,2,3,4 back-to-back -> out_result 1,2,3,4 on consecutive cycles, in_ready stays 1, state never TWO.
- Backpressure: out_ready=0, send 0xA then 0xB -> in_ready=0 after second accept, out_result holds 0xA; raise out_ready -> 0xA, then 0xB emitted, in_ready=1 after first emit.
- Flags: accept in_set_flags=1 with N=1,Z=0,C=1,V=0 -> flags=1010; next accept with in_set_flags=0 and Z=1 -> flags stay 1010; cond=B(LT) -> cond_true=1, cond=A(GE) -> 0.
- Condition sweep: force flags to each of 16 NZCV values via set_flags entries, sweep cond 0-F -> cond_true matches table; E always 1, F always 0.
- Refused input: state TWO, in_valid=1, in_set_flags=1 -> flags unchanged, entry not captured.
